// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute-stage ALU with registered result and compare flags.
// Add/sub/logic/compare/pass complete in one cycle. SLL/SRL use an iterative
// one-bit-per-cycle shifter, and busy holds off new requests while it runs.
module alu_seq_exec #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [3:0]      ALUSelection,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            cf,
  output logic            vf,
  output logic            sf,
  output logic            busy,
  output logic            done
);

  // Shared ALU_* operation encodings
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_PASS = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic            zf_q, zf_d, cf_q, cf_d, vf_q, vf_d, sf_q, sf_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic            accept;
  logic            is_shift;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] acc_shifted;

  // Single-cycle ALU operations; unknown codes behave as PASS
  function automatic logic [XLEN-1:0] alu_op(input logic [3:0] op,
                                             input logic [XLEN-1:0] x,
                                             input logic [XLEN-1:0] y);
    logic [XLEN-1:0] r;
    case (op)
      ALU_ADD:  r = x + y;
      ALU_SUB:  r = x - y;
      ALU_AND:  r = x & y;
      ALU_OR:   r = x | y;
      ALU_XOR:  r = x ^ y;
      ALU_SLT:  r = ($signed(x) < $signed(y)) ? XLEN'(1) : '0;
      ALU_SLTU: r = (x < y) ? XLEN'(1) : '0;
      default:  r = y;
    endcase
    return r;
  endfunction

  assign accept      = start & ~busy_q & ~flush;
  assign is_shift    = (ALUSelection == ALU_SLL) || (ALUSelection == ALU_SRL);
  assign diff        = {1'b0, a} - {1'b0, b};
  assign acc_shifted = (op_q == ALU_SLL) ? {acc_q[XLEN-2:0], 1'b0}
                                         : {1'b0, acc_q[XLEN-1:1]};

  // State and datapath registers, all cleared by asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      vf_q     <= 1'b0;
      sf_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      vf_q     <= vf_d;
      sf_q     <= sf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state: flush wins over start; the last shift step lands in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SHIFT: begin
        if (flush)                     state_d = S_IDLE;
        else if (cnt_q == SHW'(1))     state_d = S_DONE;
        else                           state_d = S_SHIFT;
      end
      default: begin
        if (flush)                     state_d = S_IDLE;
        else if (accept && is_shift && (b[SHW-1:0] != '0)) state_d = S_SHIFT;
        else if (accept)               state_d = S_DONE;
        else                           state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: sample operands and flags at accept, step the shifter in SHIFT
  always_comb begin
    result_d = result_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    vf_d     = vf_q;
    sf_d     = sf_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept) begin
      op_d  = ALUSelection;
      acc_d = a;
      cnt_d = b[SHW-1:0];
      zf_d  = (a == b);
      cf_d  = ~diff[XLEN];
      vf_d  = (a[XLEN-1] ^ b[XLEN-1]) & (a[XLEN-1] ^ diff[XLEN-1]);
      sf_d  = diff[XLEN-1];
      if (is_shift) begin
        if (b[SHW-1:0] == '0) result_d = a;
      end else begin
        result_d = alu_op(ALUSelection, a, b);
      end
    end else if (state_q == S_SHIFT) begin
      acc_d = acc_shifted;
      cnt_d = cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) result_d = acc_shifted;
    end
  end

  // Registered status outputs derived from the upcoming state
  always_comb begin
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  assign result = result_q;
  assign zf     = zf_q;
  assign cf     = cf_q;
  assign vf     = vf_q;
  assign sf     = sf_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Testbench for alu_seq_exec: scoreboard of expected results, one task per feature.
module tb_alu_seq_exec;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic        zf, cf, vf, sf, busy, done;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {zf, cf, vf, sf}
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  alu_seq_exec #(.XLEN(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .ALUSelection(sel),
    .a(a), .b(b), .result(result), .zf(zf), .cf(cf), .vf(vf), .sf(sf),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sd;
    logic [31:0] d;
    case (op)
      ALU_ADD:  e.res = x + y;
      ALU_SUB:  e.res = x - y;
      ALU_AND:  e.res = x & y;
      ALU_OR:   e.res = x | y;
      ALU_XOR:  e.res = x ^ y;
      ALU_SLT:  e.res = (longint'($signed(x)) < longint'($signed(y))) ? 32'd1 : 32'd0;
      ALU_SLTU: e.res = (x < y) ? 32'd1 : 32'd0;
      ALU_SLL:  e.res = x << y[4:0];
      ALU_SRL:  e.res = x >> y[4:0];
      default:  e.res = y;
    endcase
    sd = longint'($signed(x)) - longint'($signed(y));
    d  = x - y;
    e.flg = {x == y, x >= y, (sd > 64'sd2147483647) || (sd < -64'sd2147483648), d[31]};
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input bit push);
    sel = op; a = x; b = y; start = 1'b1;
    if (push) q.push_back(model(op, x, y));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int edges, output int busy_n);
    edges = 0; busy_n = 0;
    while (!done && edges < max) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({result, zf, cf, vf, sf, busy, done} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h flags=%b busy=%b done=%b, need all 0",
               result, {zf, cf, vf, sf}, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_single;
    logic [3:0]  ops[5] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND};
    logic [31:0] xs[5]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hF0F0_1234};
    logic [31:0] ys[5]  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h0FF0_FF00};
    exp_t e;
    int   edges, bn;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], xs[i], ys[i], 1'b1);
      wait_done(5, edges, bn);
      e = q.pop_front();
      checks++;
      if (edges !== 0 || !done) begin
        errors++;
        $display("FAIL single_latency op=%h: got edges=%0d done=%b, need 0 and 1", ops[i], edges, done);
      end
      checks++;
      if (result !== e.res || {zf, cf, vf, sf} !== e.flg) begin
        errors++;
        $display("FAIL single_result op=%h: got res=%h flags=%b, need res=%h flags=%b",
                 ops[i], result, {zf, cf, vf, sf}, e.res, e.flg);
      end
      step(1);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse op=%h: got done=%b one cycle later, need 0", ops[i], done);
      end
    end
  endtask

  task automatic test_shift;
    exp_t e;
    int   edges, bn;
    issue(ALU_SLL, 32'h1, 32'd31, 1'b1);
    wait_done(40, edges, bn);
    e = q.pop_front();
    checks++;
    if (!done || edges !== 31 || bn !== 31) begin
      errors++;
      $display("FAIL sll31_timing: got done=%b edges=%0d busy_cycles=%0d, need 1/31/31", done, edges, bn);
    end
    checks++;
    if (result !== e.res || {zf, cf, vf, sf} !== e.flg) begin
      errors++;
      $display("FAIL sll31_result: got res=%h flags=%b, need res=%h flags=%b",
               result, {zf, cf, vf, sf}, e.res, e.flg);
    end
    issue(ALU_SRL, 32'h8000_0000, 32'd0, 1'b1);
    wait_done(5, edges, bn);
    e = q.pop_front();
    checks++;
    if (!done || edges !== 0 || result !== e.res) begin
      errors++;
      $display("FAIL srl0: got done=%b edges=%0d res=%h, need 1/0/%h", done, edges, result, e.res);
    end
    step(1);
    issue(ALU_SRL, 32'hF000_00F0, 32'd4, 1'b1);
    wait_done(10, edges, bn);
    e = q.pop_front();
    checks++;
    if (!done || edges !== 4 || result !== e.res) begin
      errors++;
      $display("FAIL srl4: got done=%b edges=%0d res=%h, need 1/4/%h", done, edges, result, e.res);
    end
    step(1);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   edges, bn, dc0;
    issue(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1);
    e = q.pop_front();
    checks++;
    if (!done || result !== e.res) begin
      errors++;
      $display("FAIL b2b_xor: got done=%b res=%h, need 1/%h", done, result, e.res);
    end
    issue(ALU_OR, 32'h1234_0000, 32'h0000_00FF, 1'b1);
    e = q.pop_front();
    checks++;
    if (!done || result !== e.res) begin
      errors++;
      $display("FAIL b2b_or: got done=%b res=%h, need 1/%h", done, result, e.res);
    end
    step(2);
    dc0 = done_cnt;
    issue(ALU_SLL, 32'h3, 32'd6, 1'b1);
    sel = ALU_ADD; a = 32'd7; b = 32'd9; start = 1'b1;
    step(2);
    start = 1'b0;
    wait_done(20, edges, bn);
    e = q.pop_front();
    checks++;
    if (!done || result !== e.res) begin
      errors++;
      $display("FAIL busy_start_shift: got done=%b res=%h, need 1/%h", done, result, e.res);
    end
    step(4);
    checks++;
    if (done_cnt - dc0 !== 1) begin
      errors++;
      $display("FAIL busy_start_ignored: got %0d done pulses, need 1", done_cnt - dc0);
    end
  endtask

  task automatic test_flush;
    logic [31:0] r0;
    int          dc0;
    r0 = result;
    issue(ALU_SRL, 32'hFFFF_FFFF, 32'd16, 1'b0);
    step(4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    dc0 = done_cnt;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== r0) begin
      errors++;
      $display("FAIL flush_state: got busy=%b done=%b res=%h, need 0/0/%h", busy, done, result, r0);
    end
    step(20);
    checks++;
    if (done_cnt !== dc0 || result !== r0) begin
      errors++;
      $display("FAIL flush_no_done: got extra pulses=%0d res=%h, need 0 and %h", done_cnt - dc0, result, r0);
    end
  endtask

  task automatic test_rst_mid;
    exp_t e;
    int   edges, bn;
    issue(ALU_SRL, 32'hFFFF_FFFF, 32'd16, 1'b0);
    step(3);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({result, zf, cf, vf, sf, busy, done} !== 38'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got res=%h flags=%b busy=%b done=%b, need all 0",
               result, {zf, cf, vf, sf}, busy, done);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    issue(ALU_ADD, 32'd5, 32'd7, 1'b1);
    wait_done(5, edges, bn);
    e = q.pop_front();
    checks++;
    if (!done || edges !== 0 || result !== e.res || {zf, cf, vf, sf} !== e.flg) begin
      errors++;
      $display("FAIL add_after_rst: got done=%b edges=%0d res=%h flags=%b, need 1/0/%h/%b",
               done, edges, result, {zf, cf, vf, sf}, e.res, e.flg);
    end
    step(1);
  endtask

  task automatic test_undef;
    exp_t e;
    int   edges, bn;
    issue(4'hF, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
    wait_done(5, edges, bn);
    e = q.pop_front();
    checks++;
    if (!done || edges !== 0 || result !== 32'h0000_1234 || result !== e.res) begin
      errors++;
      $display("FAIL undef_pass: got done=%b edges=%0d res=%h, need 1/0/00001234", done, edges, result);
    end
    step(1);
  endtask

  initial begin
    test_reset;
    test_single;
    test_shift;
    test_back_to_back;
    test_flush;
    test_rst_mid;
    test_undef;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
